// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: prioritises exceptions and interrupts, updates EPC/Cause/Status/BadVAddr, and provides MTC0/MFC0 access.
// Latency: commit at edge T, flush is high in cycle T+1 and redirect_valid in cycle T+2; MFC0 read data is combinational.
// Backpressure: busy is high in FLUSH and REDIRECT, upstream must stall commit, and commit_valid is ignored while busy.
module cp0_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        commit_valid,
   input  logic        addr_err_f,
   input  logic        cache_err_f,
   input  logic        bus_err_f,
   input  logic        cp0_unused,
   input  logic        instr_undefine,
   input  logic        overflow,
   input  logic        trap,
   input  logic        syscall,
   input  logic        break_point,
   input  logic        addr_err_m,
   input  logic        cache_err_m,
   input  logic        bus_err_m,
   input  logic        mem_is_store,
   input  logic [31:0] pc_m,
   input  logic        in_delay_slot,
   input  logic [31:0] bad_vaddr_in,
   input  logic        eret,
   input  logic [5:0]  hw_int,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

   state_t      state_q, state_d;
   logic [31:0] epc_q, cause_q, status_q, badv_q, tgt_q;
   logic        any_flag, int_pending, take_exc, take_eret, do_mtc0;
   logic        badv_from_pc, badv_from_mem;
   logic [4:0]  exc_code;

   // Interrupt is pending when an unmasked IP line is set, IE=1 and EXL=0.
   assign int_pending = (|({hw_int, cause_q[9:8]} & status_q[15:8])) & status_q[0] & ~status_q[1];

   assign any_flag = addr_err_f | cache_err_f | bus_err_f | cp0_unused | instr_undefine |
                     overflow | trap | syscall | break_point | addr_err_m | cache_err_m | bus_err_m;

   assign take_exc  = (state_q == IDLE) & commit_valid & (any_flag | int_pending);
   assign take_eret = (state_q == IDLE) & commit_valid & eret & ~take_exc;
   assign do_mtc0   = (state_q == IDLE) & commit_valid & cp0_we & ~take_exc & ~take_eret;

   // Fixed-priority pick of the winning ExcCode; also selects the BadVAddr source.
   always_comb begin
      exc_code      = 5'd0;
      badv_from_pc  = 1'b0;
      badv_from_mem = 1'b0;
      if      (addr_err_f)     begin exc_code = 5'd4; badv_from_pc = 1'b1; end
      else if (cache_err_f)    exc_code = 5'd30;
      else if (bus_err_f)      exc_code = 5'd6;
      else if (cp0_unused)     exc_code = 5'd11;
      else if (instr_undefine) exc_code = 5'd10;
      else if (overflow)       exc_code = 5'd12;
      else if (trap)           exc_code = 5'd13;
      else if (syscall)        exc_code = 5'd8;
      else if (break_point)    exc_code = 5'd9;
      else if (addr_err_m)     begin exc_code = mem_is_store ? 5'd5 : 5'd4; badv_from_mem = 1'b1; end
      else if (cache_err_m)    exc_code = 5'd30;
      else if (bus_err_m)      exc_code = 5'd7;
      else                     exc_code = 5'd0;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and sequencing outputs.
   always_comb begin
      state_d        = state_q;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      busy           = 1'b0;
      case (state_q)
         IDLE:     if (take_exc || take_eret) state_d = FLUSH;
         FLUSH:    begin flush = 1'b1; busy = 1'b1; state_d = REDIRECT; end
         REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = tgt_q;
            busy           = 1'b1;
            state_d        = IDLE;
         end
         default:  state_d = IDLE;
      endcase
   end

   // CP0 register updates: exception entry wins over ERET, which wins over MTC0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epc_q    <= 32'd0;
         cause_q  <= 32'd0;
         status_q <= STATUS_RST;
         badv_q   <= 32'd0;
         tgt_q    <= 32'd0;
      end else begin
         cause_q[15:10] <= hw_int;
         if (take_exc) begin
            cause_q[6:2] <= exc_code;
            if (!status_q[1]) begin
               epc_q       <= in_delay_slot ? (pc_m - 32'd4) : pc_m;
               cause_q[31] <= in_delay_slot;
            end
            status_q[1] <= 1'b1;
            if (badv_from_pc)       badv_q <= pc_m;
            else if (badv_from_mem) badv_q <= bad_vaddr_in;
            tgt_q <= EXC_VECTOR;
         end else if (take_eret) begin
            status_q[1] <= 1'b0;
            tgt_q       <= epc_q;
         end else if (do_mtc0) begin
            case (cp0_addr)
               5'd12:   status_q     <= cp0_wdata;
               5'd13:   cause_q[9:8] <= cp0_wdata[9:8];
               5'd14:   epc_q        <= cp0_wdata;
               default: ;
            endcase
         end
      end
   end

   // MFC0 read mux; unimplemented numbers read zero.
   always_comb begin
      cp0_rdata = 32'd0;
      case (cp0_addr)
         5'd8:    cp0_rdata = badv_q;
         5'd12:   cp0_rdata = status_q;
         5'd13:   cp0_rdata = cause_q;
         5'd14:   cp0_rdata = epc_q;
         default: cp0_rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
module tb_cp0_exc_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        commit_valid;
   logic        addr_err_f, cache_err_f, bus_err_f, cp0_unused, instr_undefine, overflow;
   logic        trap, syscall, break_point, addr_err_m, cache_err_m, bus_err_m;
   logic        mem_is_store;
   logic [31:0] pc_m;
   logic        in_delay_slot;
   logic [31:0] bad_vaddr_in;
   logic        eret;
   logic [5:0]  hw_int;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        flush, redirect_valid, busy;
   logic [31:0] redirect_pc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cp0_exc_ctrl dut (
      .clk(clk), .rst_n(rst_n), .commit_valid(commit_valid),
      .addr_err_f(addr_err_f), .cache_err_f(cache_err_f), .bus_err_f(bus_err_f),
      .cp0_unused(cp0_unused), .instr_undefine(instr_undefine), .overflow(overflow),
      .trap(trap), .syscall(syscall), .break_point(break_point),
      .addr_err_m(addr_err_m), .cache_err_m(cache_err_m), .bus_err_m(bus_err_m),
      .mem_is_store(mem_is_store), .pc_m(pc_m), .in_delay_slot(in_delay_slot),
      .bad_vaddr_in(bad_vaddr_in), .eret(eret), .hw_int(hw_int),
      .cp0_we(cp0_we), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata), .cp0_rdata(cp0_rdata),
      .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      cp0_addr = a;
      #1;
      chk(tag, cp0_rdata, exp);
   endtask

   task automatic clear_in();
      commit_valid = 0; addr_err_f = 0; cache_err_f = 0; bus_err_f = 0; cp0_unused = 0;
      instr_undefine = 0; overflow = 0; trap = 0; syscall = 0; break_point = 0;
      addr_err_m = 0; cache_err_m = 0; bus_err_m = 0; mem_is_store = 0;
      pc_m = 0; in_delay_slot = 0; bad_vaddr_in = 0; eret = 0; cp0_we = 0; cp0_wdata = 0;
   endtask

   // Commit edge, then check the FLUSH cycle, the REDIRECT cycle and the return to IDLE.
   task automatic run_seq(input string tag, input logic [31:0] exp_pc);
      tick();
      clear_in();
      chk({tag, "_flush"}, {31'd0, flush}, 32'd1);
      chk({tag, "_busy1"}, {31'd0, busy}, 32'd1);
      chk({tag, "_rv_early"}, {31'd0, redirect_valid}, 32'd0);
      tick();
      chk({tag, "_rv"}, {31'd0, redirect_valid}, 32'd1);
      chk({tag, "_rpc"}, redirect_pc, exp_pc);
      chk({tag, "_flush_off"}, {31'd0, flush}, 32'd0);
      chk({tag, "_busy2"}, {31'd0, busy}, 32'd1);
      tick();
      chk({tag, "_idle"}, {29'd0, busy, flush, redirect_valid}, 32'd0);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      commit_valid = 1; cp0_we = 1; cp0_addr = a; cp0_wdata = d;
      tick();
      clear_in();
   endtask

   initial begin
      clear_in();
      hw_int = 0;
      cp0_addr = 0;
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;

      // Reset state
      rd("rst_badv", 5'd8, 32'd0);
      rd("rst_status", 5'd12, 32'h0040_0000);
      rd("rst_cause", 5'd13, 32'd0);
      rd("rst_epc", 5'd14, 32'd0);
      chk("rst_outs", {29'd0, busy, flush, redirect_valid}, 32'd0);
      chk("rst_rpc", redirect_pc, 32'd0);
      tick();

      // SYSCALL, not in delay slot
      commit_valid = 1; syscall = 1; pc_m = 32'h8000_0100;
      run_seq("sys", 32'hBFC0_0380);
      rd("sys_epc", 5'd14, 32'h8000_0100);
      rd("sys_cause", 5'd13, 32'h0000_0020);
      rd("sys_status", 5'd12, 32'h0040_0002);

      // Clear EXL via MTC0, then overflow + break in delay slot: overflow wins
      mtc0(5'd12, 32'h0040_0000);
      chk("mtc0_nobusy", {31'd0, busy}, 32'd0);
      rd("mtc0_status", 5'd12, 32'h0040_0000);
      commit_valid = 1; overflow = 1; break_point = 1; in_delay_slot = 1; pc_m = 32'h8000_0100;
      run_seq("ov", 32'hBFC0_0380);
      rd("ov_epc", 5'd14, 32'h8000_00FC);
      rd("ov_cause", 5'd13, 32'h8000_0030);
      rd("ov_status", 5'd12, 32'h0040_0002);

      // Store address error while EXL=1: EPC and BD unchanged
      commit_valid = 1; addr_err_m = 1; mem_is_store = 1; bad_vaddr_in = 32'h1234_5673;
      pc_m = 32'h8000_0300;
      run_seq("ades", 32'hBFC0_0380);
      rd("ades_cause", 5'd13, 32'h8000_0014);
      rd("ades_badv", 5'd8, 32'h1234_5673);
      rd("ades_epc", 5'd14, 32'h8000_00FC);

      // BadVAddr is read-only; unimplemented register reads zero
      mtc0(5'd8, 32'hDEAD_BEEF);
      rd("badv_ro", 5'd8, 32'h1234_5673);
      rd("unimpl", 5'd9, 32'd0);

      // Interrupt: IP2 already high; enabling IE does not trap on the MTC0 itself
      hw_int = 6'b000001;
      tick();
      mtc0(5'd12, 32'h0000_0401);
      chk("int_same_cycle", {31'd0, busy}, 32'd0);
      rd("int_status", 5'd12, 32'h0000_0401);
      commit_valid = 1; pc_m = 32'h8000_0200;
      run_seq("int", 32'hBFC0_0380);
      rd("int_cause", 5'd13, 32'h0000_0400);
      rd("int_epc", 5'd14, 32'h8000_0200);
      rd("int_status2", 5'd12, 32'h0000_0403);

      // ERET returns to EPC and clears EXL
      hw_int = 0;
      tick();
      commit_valid = 1; eret = 1;
      run_seq("eret", 32'h8000_0200);
      rd("eret_status", 5'd12, 32'h0000_0401);

      // Reset asserted during FLUSH: no redirect, registers back to reset values
      commit_valid = 1; syscall = 1; pc_m = 32'h8000_0500;
      tick();
      clear_in();
      chk("rf_flush", {31'd0, flush}, 32'd1);
      #1;
      rst_n = 0;
      #1;
      chk("rf_outs_now", {29'd0, busy, flush, redirect_valid}, 32'd0);
      tick();
      chk("rf_no_rv", {29'd0, busy, flush, redirect_valid}, 32'd0);
      chk("rf_rpc", redirect_pc, 32'd0);
      rst_n = 1;
      tick();
      chk("rf_idle", {29'd0, busy, flush, redirect_valid}, 32'd0);
      rd("rf_epc", 5'd14, 32'd0);
      rd("rf_status", 5'd12, 32'h0040_0000);
      rd("rf_cause", 5'd13, 32'd0);
      rd("rf_badv", 5'd8, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
